// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, KILL} state_t;
  localparam logic [1:0] PCSRC_BR = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response bus
interface fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic req;
  logic [ADDR_WIDTH-1:0] addr;
  logic rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  modport master (output req, addr, input rvalid, rdata);
  modport slave (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush > stall > load priority and bubble insertion
module if_id_reg import fetch_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic stall,
  input  logic load,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instrd,
  output logic [ADDR_WIDTH-1:0] pcd,
  output logic [ADDR_WIDTH-1:0] pcplus4d,
  output logic validd
);
  always_ff @(posedge clk)
    if (!rst) begin
      instrd <= DATA_WIDTH'(NOP);
      pcd <= '0;
      pcplus4d <= '0;
      validd <= 1'b0;
    end else if (flush || (!stall && !load)) begin
      instrd <= DATA_WIDTH'(NOP);
      validd <= 1'b0;
    end else if (!stall) begin
      instrd <= instr;
      pcd <= pc;
      pcplus4d <= pc + ADDR_WIDTH'(4);
      validd <= 1'b1;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: fetch PC, instruction-cache request and redirect handling feeding the IF/ID register
module fetch_stage import fetch_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  input  logic stallf,
  input  logic stalld,
  input  logic flushd,
  input  logic [1:0] pcsrce,
  input  logic [ADDR_WIDTH-1:0] pctargete,
  input  logic [ADDR_WIDTH-1:0] aluresulte,
  fetch_if.master imem,
  output logic fetch_miss,
  output logic [ADDR_WIDTH-1:0] pcf,
  output logic [DATA_WIDTH-1:0] instrd,
  output logic [ADDR_WIDTH-1:0] pcd,
  output logic [ADDR_WIDTH-1:0] pcplus4d,
  output logic validd
);
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] pc_next, redir_q, redir_next, target;
  logic redirect;
  assign redirect = pcsrce == PCSRC_BR || pcsrce == PCSRC_JALR;
  assign target = pcsrce == PCSRC_JALR ? aluresulte & ~ADDR_WIDTH'(1) : pctargete;
  assign imem.req = rst && state != IDLE;
  assign imem.addr = pcf;
  assign fetch_miss = imem.req && !imem.rvalid;
  always_comb begin
    state_next = state;
    pc_next = pcf;
    redir_next = redir_q;
    case (state)
      IDLE: state_next = trigger ? FETCH : IDLE;
      FETCH:
        if (redirect && imem.rvalid) pc_next = target;
        else if (redirect) begin
          redir_next = target;
          state_next = KILL;
        end else if (imem.rvalid && !stallf) pc_next = pcf + ADDR_WIDTH'(4);
      KILL: begin
        redir_next = redirect ? target : redir_q;
        pc_next = imem.rvalid ? redir_next : pcf;
        state_next = imem.rvalid ? FETCH : KILL;
      end
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      pcf <= RESET_PC;
      redir_q <= '0;
    end else begin
      state <= state_next;
      pcf <= pc_next;
      redir_q <= redir_next;
    end
  if_id_reg #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_if_id (
    .clk(clk),
    .rst(rst),
    .flush(flushd),
    .stall(stalld),
    .load(state == FETCH && imem.rvalid),
    .instr(imem.rdata),
    .pc(pcf),
    .instrd(instrd),
    .pcd(pcd),
    .pcplus4d(pcplus4d),
    .validd(validd)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic trigger = 1'b0;
  logic stallf = 1'b0;
  logic stalld = 1'b0;
  logic flushd = 1'b0;
  logic [1:0] pcsrce = 2'b00;
  logic [31:0] pctargete = '0;
  logic [31:0] aluresulte = '0;
  logic fetch_miss;
  logic [31:0] pcf, instrd, pcd, pcplus4d;
  logic validd;
  int checks = 0;
  int errors = 0;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  bit m_run, m_disc, m_valid;
  logic [31:0] m_pc, m_redir, m_instr, m_pcd, m_pc4;
  fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem ();
  fetch_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .trigger(trigger),
    .stallf(stallf),
    .stalld(stalld),
    .flushd(flushd),
    .pcsrce(pcsrce),
    .pctargete(pctargete),
    .aluresulte(aluresulte),
    .imem(imem.master),
    .fetch_miss(fetch_miss),
    .pcf(pcf),
    .instrd(instrd),
    .pcd(pcd),
    .pcplus4d(pcplus4d),
    .validd(validd)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_run = 0;
    m_disc = 0;
    m_pc = 32'h0;
    m_redir = 32'h0;
    m_instr = NOP_WORD;
    m_pcd = 32'h0;
    m_pc4 = 32'h0;
    m_valid = 0;
  endtask
  task automatic model_update();
    logic red;
    logic [31:0] tgt, ret;
    red = pcsrce == 2'b01 || pcsrce == 2'b10;
    ret = aluresulte;
    tgt = pcsrce == 2'b10 ? {ret[31:1], 1'b0} : pctargete;
    if (!rst) model_reset();
    else begin
      if (flushd || (!stalld && !(m_run && !m_disc && imem.rvalid))) begin
        m_instr = NOP_WORD;
        m_valid = 0;
      end else if (!stalld) begin
        m_instr = m_pc ^ 32'hA5A5_0000;
        m_pcd = m_pc;
        m_pc4 = m_pc + 32'd4;
        m_valid = 1;
      end
      if (!m_run) m_run = trigger;
      else if (m_disc) begin
        if (red) m_redir = tgt;
        if (imem.rvalid) begin
          m_pc = m_redir;
          m_disc = 0;
        end
      end else if (red) begin
        if (imem.rvalid) m_pc = tgt;
        else begin
          m_redir = tgt;
          m_disc = 1;
        end
      end else if (imem.rvalid && !stallf) m_pc = m_pc + 32'd4;
    end
  endtask
  task automatic step();
    imem.rdata = m_pc ^ 32'hA5A5_0000;
    #1;
    chk("imem_req", {31'b0, imem.req}, {31'b0, rst && m_run});
    chk("fetch_miss", {31'b0, fetch_miss}, {31'b0, rst && m_run && !imem.rvalid});
    if (rst && m_run) chk("imem_addr", imem.addr, m_pc);
    chk("pcf", pcf, m_pc);
    model_update();
    @(posedge clk);
    #1;
    chk("instrd", instrd, m_instr);
    chk("pcd", pcd, m_pcd);
    chk("pcplus4d", pcplus4d, m_pc4);
    chk("validd", {31'b0, validd}, {31'b0, m_valid});
  endtask
  initial begin
    imem.rvalid = 1'b0;
    imem.rdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b1;
    step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    imem.rvalid = 1'b1;
    repeat (2) step();
    imem.rvalid = 1'b0;
    repeat (3) step();
    chk("miss_pc_held", pcf, 32'h8);
    imem.rvalid = 1'b1;
    step();
    chk("miss_loaded", instrd, 32'hA5A5_0008);
    repeat (5) step();
    imem.rvalid = 1'b0;
    step();
    pcsrce = 2'b01;
    pctargete = 32'h100;
    flushd = 1'b1;
    step();
    pcsrce = 2'b00;
    flushd = 1'b0;
    step();
    chk("kill_addr", imem.addr, 32'h20);
    imem.rvalid = 1'b1;
    step();
    chk("redirect_pc", pcf, 32'h100);
    step();
    pcsrce = 2'b10;
    aluresulte = 32'h201;
    step();
    chk("jalr_pc", pcf, 32'h200);
    pcsrce = 2'b00;
    step();
    stallf = 1'b1;
    stalld = 1'b1;
    repeat (2) step();
    flushd = 1'b1;
    step();
    chk("flush_nop", instrd, NOP_WORD);
    stallf = 1'b0;
    stalld = 1'b0;
    flushd = 1'b0;
    pcsrce = 2'b01;
    pctargete = 32'hFFFF_FFFC;
    step();
    pcsrce = 2'b00;
    step();
    chk("wrap_pc", pcf, 32'h0);
    step();
    imem.rvalid = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    imem.rvalid = 1'b1;
    repeat (2) step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(63) != 0;
      trigger = $urandom_range(3) == 0;
      stallf = $urandom_range(7) == 0;
      stalld = $urandom_range(7) == 0;
      flushd = $urandom_range(7) == 0;
      pcsrce = $urandom_range(5) == 0 ? 2'($urandom_range(3, 1)) : 2'b00;
      pctargete = $urandom & ~32'h3;
      aluresulte = $urandom;
      imem.rvalid = $urandom_range(9) < 7;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RISC-V core: owns the fetch PC, drives the instruction-cache request, and loads the IF/ID pipeline register. It consumes the hazard unit's stallf, stalld and flushd together with the execute-stage redirect (pcsrce plus targets). It stalls itself on cache misses and discards a stale in-flight fetch after a redirect.

## Interface
- ADDR_WIDTH, 32: PC and instruction-address width.
- DATA_WIDTH, 32: instruction width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous and active-low (0 = reset).
- trigger  input  1  CPU start; fetch begins the cycle after it is sampled high.
- stallf  input  1  hazard unit: hold PC.
- stalld  input  1  hazard unit: hold IF/ID register.
- flushd  input  1  hazard unit: bubble IF/ID register.
- pcsrce  input  2  00 sequential, 01 branch/jal (pctargete), 10 jalr (aluresulte), 11 reserved (treated as 00).
- pctargete  input  ADDR_WIDTH  branch/jal target from execute.
- aluresulte  input  ADDR_WIDTH  jalr target from execute; bit 0 forced to 0.
- imem_req  output  1  fetch request valid.
- imem_addr  output  ADDR_WIDTH  fetch address; stable while imem_req=1 and no imem_rvalid.
- imem_rvalid  input  1  response valid; same cycle as request (hit) or later (miss).
- imem_rdata  input  DATA_WIDTH  instruction word, valid with imem_rvalid.
- fetch_miss  output  1  request outstanding without response this cycle (perf/debug).
- pcf  output  ADDR_WIDTH  current fetch PC.
- instrd, pcd, pcplus4d  output  DATA_WIDTH/ADDR_WIDTH  IF/ID register contents.
- validd  output  1  IF/ID holds a real instruction.

## Operation
- States: IDLE, FETCH, KILL.
- IDLE: imem_req=0, pcf=RESET_PC. trigger=1 moves to FETCH. Ignored afterwards.
- FETCH: imem_req=1, imem_addr=pcf.
  - imem_rvalid=1 and no redirect and stallf=0: pcf<=pcf+4.
  - stallf=1: pcf holds and the same PC is refetched next cycle.
- Redirect = pcsrce in {01,10}. It has priority over stallf.
  - FETCH with imem_rvalid=1: pcf<=target, stay FETCH.
  - FETCH with imem_rvalid=0: latch target into redir_q, go KILL. imem_addr stays at the old pcf.
- KILL: imem_req=1 at the old address. A new redirect overwrites redir_q. On imem_rvalid, the response is discarded, pcf<=redir_q, go FETCH.
- IF/ID load, priority rst > flushd > stalld > load:
  - Load with FETCH & imem_rvalid: instrd=imem_rdata, pcd=pcf, pcplus4d=pcf+4, validd=1.
  - Load otherwise (miss, KILL, IDLE): bubble.
  - Bubble = instrd 32'h0000_0013 (NOP), validd=0, pcd/pcplus4d unchanged.
- fetch_miss = imem_req & ~imem_rvalid.
- PC arithmetic is modulo 2^ADDR_WIDTH; wrap from all-ones-minus-3 to 0 is legal.

## Timing
- Reset (rst=0 at edge): state IDLE, pcf=RESET_PC, redir_q=0, instrd=NOP, pcd=0, pcplus4d=0, validd=0. Combinational imem_req=0 and fetch_miss=0 in the same cycle.
- Reset mid-miss abandons the request. The cache must tolerate imem_req falling without a response.
- Hit latency: instruction in IF/ID one edge after the request cycle. Sustained throughput is 1 per cycle.
- Miss: pcf and imem_addr are frozen, and IF/ID receives bubbles each cycle unless stalld or flushd apply.
- Redirect in cycle N: fetch of the target issues in N+1 on a hit path. On a pending miss it issues the cycle after the killed response.
- Simultaneous flushd and stalld: flush wins.
- Simultaneous redirect and stallf: redirect wins.

## Structure
- fetch_pkg: state enum (IDLE/FETCH/KILL), pcsrc encodings, NOP constant 32'h0000_0013.
- Sub-module if_id_reg: IF/ID register with flush/stall/load priority and the bubble insertion. fetch_stage holds the FSM, PC and redir_q.

## Test plan
- Reset, trigger at cycle 3, always-hit memory returning addr^32'hA5A5_0000 -> imem_addr 0,4,8,... from cycle 4; instrd follows one edge later with validd=1.
- 3-cycle miss at PC 0x8 -> fetch_miss=1 for 3 cycles, pcf held at 0x8, validd=0 bubbles; instruction at 0x8 loaded on the response edge.
- Redirect pcsrce=01 to 0x100 with flushd during a miss at 0x20 -> state KILL; the 0x20 data never reaches instrd; next request is at 0x100.
- pcsrce=10, aluresulte=0x201 -> next fetch address 0x200.
- stallf=stalld=1 for 2 cycles on the hit path -> pcf and IF/ID unchanged; flushd together with stalld -> IF/ID becomes NOP, validd=0.
- rst=0 while a miss is pending -> imem_req=0 the same cycle, all outputs at reset values next edge; trigger is required again before fetching.
